tdc_multi_channel_core: RTL and testbench
=========================================

TDC_MULTI_CHANNEL_CORE -- requirements
Module: tdc_multi_channel_core

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of stop channels, 1..8.
REQ-002 SHALL have parameter CNT_W, default 12: coarse counter and result width, 4..16.
REQ-003 SHALL have parameter AVG_LOG2, default 2: averaging depth of 2^AVG_LOG2 shots, 0..4.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start_i, input, 1: common start; only its rising edge is used.
REQ-007 SHALL have port stop_i, input, N_CH: per-channel stop; only rising edges are used.
REQ-008 SHALL have port mode_i, input, 1: 0 = single-shot, 1 = averaging.
REQ-009 SHALL have port rd_i, input, 1: readout strobe.
REQ-010 SHALL have port ch_sel_i, input, 3: readout channel.
REQ-011 SHALL have port byte_sel_i, input, 2: readout byte, 0 = result[7:0], 1 = result[15:8] zero-extended, 2 = status, 3 = 0x00.
REQ-012 SHALL have port data_o, output, 8: registered readout byte.
REQ-013 SHALL have port busy_o, output, 1: high while in ARMED or DONE.
REQ-014 SHALL have port valid_o, output, 1: result registers hold a completed batch.

Function
REQ-015 SHALL detect edges with one register per input: edge = input high now and low in the previous clk.
REQ-016 SHALL implement FSM IDLE -> ARMED -> DONE -> IDLE.
REQ-017 IDLE: on start edge, set cnt = 1, clear per-channel captured flags, go to ARMED; sample mode_i here only if shot_cnt = 0.
REQ-018 ARMED: cnt increments by 1 each clk; a stop edge on an uncaptured channel stores cnt into cap[ch] and sets its flag.
REQ-019 A stop edge in the same clk as the start edge, in IDLE or in DONE SHALL be ignored; repeat stops on a captured channel SHALL be ignored.
REQ-020 Start edges outside IDLE SHALL be ignored.
REQ-021 ARMED -> DONE when all flags are set, or when cnt = 2^CNT_W-1 (timeout).
REQ-022 On timeout, every uncaptured channel SHALL get cap = 2^CNT_W-1 and ovf[ch] = 1; a stop edge in the timeout clk SHALL still capture normally.
REQ-023 DONE lasts 1 clk: acc[ch] += cap[ch] (width CNT_W+AVG_LOG2, no overflow possible) and shot_cnt increments.
REQ-024 In single mode, or when shot_cnt reaches 2^AVG_LOG2, DONE SHALL load res[ch] = acc[ch] >> AVG_LOG2 (truncating), then clear acc and shot_cnt.
REQ-025 In single mode the shift SHALL be 0; res = cap.
REQ-026 On that load, valid_o SHALL be set and stay set until the next start edge that begins a batch (shot_cnt = 0).
REQ-027 ovf[ch] SHALL be sticky across a batch and SHALL clear at the start of a new batch.
REQ-028 A rd_i pulse in clk k SHALL update data_o in clk k+1 with the selected byte.
REQ-029 data_o SHALL hold its value when rd_i is low.
REQ-030 ch_sel_i >= N_CH SHALL return 0x00.
REQ-031 The status byte SHALL be {ovf[ch], valid_o, busy_o, mode_latched, 4'b0} (MSB first).
REQ-032 Readout SHALL be legal in any state and SHALL NOT disturb measurement.

Reset
REQ-033 On rst_n low, asynchronously: FSM = IDLE; cnt, cap, acc, res, shot_cnt, ovf, flags and edge registers = 0; data_o = 0x00; busy_o = 0; valid_o = 0.
REQ-034 Reset mid-ARMED or mid-batch SHALL discard partial data; the first start after release begins a new batch.

Verification
REQ-035 Single mode: start edge, then stop[0] 5 clk later and stop[1] 9 clk later, stop[2] and stop[3] 3 clk later -> res = 5, 9, 3, 3; valid_o = 1; ovf = 0.
REQ-036 Timeout: CNT_W = 12, start, then stop[0] only at clk 100 -> res[0] = 100, res[1..3] = 4095, status ovf bits set for ch1..3, busy_o low after DONE.
REQ-037 Averaging, AVG_LOG2 = 2: four shots with ch0 intervals 10, 11, 12, 14 -> res[0] = 11; valid_o rises only after the fourth DONE.
REQ-038 Edge cases: stop coincident with start, then a second start while ARMED, then a repeated stop -> all ignored; the capture equals the first legal stop.
REQ-039 Readout: res[1] = 0x0ABC, rd with ch 1 / byte 0 then byte 1, then rd with ch 7 -> data_o = 0xBC, then 0x0A, then 0x00, each one clk after rd_i.
REQ-040 Reset mid-ARMED after 3 shots of an averaging batch -> all outputs 0; the next 4 shots produce a fresh average.

Source files
------------

// File: rtl/tdc_multi_channel_core.sv
// -----------------------------------------------------------------------------
// tdc_multi_channel_core
//
// Multi-channel coarse time-to-digital converter.
//
// A common start edge launches a coarse counter. Each stop channel captures the
// counter value on its first rising edge. Channels that never stop before the
// counter reaches its maximum are forced to full scale and flagged as overflow.
// In averaging mode, 2^AVG_LOG2 shots are accumulated per channel before the
// truncated mean is published. Results are read back one byte at a time.
//
// Ports
//   clk        : single clock; all logic is rising-edge
//   rst_n      : asynchronous active-low reset
//   start_i    : common start (rising edge used)
//   stop_i     : per-channel stop, N_CH bits (rising edges used)
//   mode_i     : 0 = single-shot, 1 = averaging (latched at batch start)
//   rd_i       : readout strobe; data_o updates on the following clock
//   ch_sel_i   : readout channel (values >= N_CH read as 0x00)
//   byte_sel_i : 0 = result[7:0], 1 = result[15:8], 2 = status, 3 = 0x00
//   data_o     : registered readout byte
//   busy_o     : high while ARMED or DONE
//   valid_o    : result registers hold a completed batch
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a start edge
// ARMED  | counter running, capturing first stop edge per channel
// DONE   | one clock: accumulate shot, publish result at batch end
// -----------------------------------------------------------------------------
module tdc_multi_channel_core #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [N_CH-1:0] stop_i,
  input  logic            mode_i,
  input  logic            rd_i,
  input  logic [2:0]      ch_sel_i,
  input  logic [1:0]      byte_sel_i,
  output logic [7:0]      data_o,
  output logic            busy_o,
  output logic            valid_o
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int SH_W  = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SH_W-1:0]  SHOTS   = SH_W'(1 << AVG_LOG2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic            start_q;
  logic [N_CH-1:0] stop_q;
  logic            start_edge;
  logic [N_CH-1:0] stop_edge;

  logic [CNT_W-1:0] cnt;
  logic [N_CH-1:0]  flags;
  logic [N_CH-1:0]  flags_nxt;
  logic [N_CH-1:0]  cap_en;
  logic [N_CH-1:0]  ovf;
  logic [SH_W-1:0]  shot_cnt;
  logic [SH_W-1:0]  shot_nxt;
  logic             mode_lat;
  logic             valid;
  logic             timeout;
  logic             batch_end;

  logic [CNT_W-1:0] cap     [N_CH];
  logic [ACC_W-1:0] acc     [N_CH];
  logic [ACC_W-1:0] acc_sum [N_CH];
  logic [CNT_W-1:0] res     [N_CH];

  logic [7:0]  rd_byte;
  logic [15:0] res16;

  assign start_edge = start_i & ~start_q;
  assign stop_edge  = stop_i & ~stop_q;
  assign timeout    = (cnt == CNT_MAX);
  assign shot_nxt   = shot_cnt + 1'b1;
  // Single mode publishes every shot; averaging waits for the full batch.
  assign batch_end  = !mode_lat || (shot_nxt == SHOTS);
  assign busy_o     = (state != S_IDLE);
  assign valid_o    = valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= '0;
    end else begin
      start_q <= start_i;
      stop_q  <= stop_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_en    = '0;
    flags_nxt = flags;
    case (state)
      S_IDLE:  if (start_edge) state_nxt = S_ARMED;
      S_ARMED: begin
        cap_en    = stop_edge & ~flags;
        flags_nxt = flags | cap_en;
        if ((&flags_nxt) || timeout) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) acc_sum[i] = acc[i] + ACC_W'(cap[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      flags    <= '0;
      ovf      <= '0;
      shot_cnt <= '0;
      mode_lat <= 1'b0;
      valid    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cap[i] <= '0;
        acc[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            cnt   <= CNT_W'(1);
            flags <= '0;
            // Mode, valid and overflow only change on the first shot of a batch.
            if (shot_cnt == '0) begin
              mode_lat <= mode_i;
              valid    <= 1'b0;
              ovf      <= '0;
            end
          end
        end
        S_ARMED: begin
          cnt   <= cnt + 1'b1;
          flags <= flags_nxt;
          for (int i = 0; i < N_CH; i++) begin
            if (cap_en[i]) begin
              cap[i] <= cnt;
            end else if (timeout && !flags_nxt[i]) begin
              cap[i] <= CNT_MAX;
              ovf[i] <= 1'b1;
            end
          end
        end
        S_DONE: begin
          for (int i = 0; i < N_CH; i++) begin
            if (batch_end) begin
              res[i] <= mode_lat ? CNT_W'(acc_sum[i] >> AVG_LOG2) : cap[i];
              acc[i] <= '0;
            end else begin
              acc[i] <= acc_sum[i];
            end
          end
          if (batch_end) begin
            shot_cnt <= '0;
            valid    <= 1'b1;
          end else begin
            shot_cnt <= shot_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    res16   = 16'h0000;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel_i == 3'(i)) begin
        res16 = 16'(res[i]);
        case (byte_sel_i)
          2'd0:    rd_byte = res16[7:0];
          2'd1:    rd_byte = res16[15:8];
          2'd2:    rd_byte = {ovf[i], valid, busy_o, mode_lat, 4'b0000};
          default: rd_byte = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data_o <= 8'h00;
    else if (rd_i) data_o <= rd_byte;
  end

endmodule

// File: tb/tb_tdc_multi_channel_core.sv
module tb_tdc_multi_channel_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [3:0] stop_i = 4'b0000;
  logic       mode_i = 1'b0;
  logic       rd_i = 1'b0;
  logic [2:0] ch_sel_i = 3'd0;
  logic [1:0] byte_sel_i = 2'd0;
  logic [7:0] data_o;
  logic       busy_o;
  logic       valid_o;

  tdc_multi_channel_core #(.N_CH(4), .CNT_W(12), .AVG_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .mode_i(mode_i), .rd_i(rd_i), .ch_sel_i(ch_sel_i), .byte_sel_i(byte_sel_i),
    .data_o(data_o), .busy_o(busy_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] last_exp = 8'h00;

  // reference model of published state
  int m_res [4];
  int m_acc [4];
  int m_ovf [4];
  int m_shot = 0;
  bit m_valid = 1'b0;
  bit m_mode = 1'b0;
  int cap_v [4];
  int ov_v  [4];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_res[i] = 0; m_acc[i] = 0; m_ovf[i] = 0;
    end
    m_shot = 0; m_valid = 1'b0; m_mode = 1'b0;
  endtask

  task automatic model_begin();
    if (m_shot == 0) begin
      m_mode  = mode_i;
      m_valid = 1'b0;
      for (int i = 0; i < 4; i++) m_ovf[i] = 0;
    end
  endtask

  task automatic model_end();
    for (int i = 0; i < 4; i++) begin
      if (ov_v[i] != 0) m_ovf[i] = 1;
      m_acc[i] += cap_v[i];
    end
    m_shot++;
    if (!m_mode || m_shot == 4) begin
      for (int i = 0; i < 4; i++) begin
        m_res[i] = m_mode ? (m_acc[i] / 4) : cap_v[i];
        m_acc[i] = 0;
      end
      m_shot  = 0;
      m_valid = 1'b1;
    end
  endtask

  function automatic logic [7:0] exp_byte(input int ch, input int b);
    int r;
    if (ch >= 4) return 8'h00;
    r = m_res[ch];
    case (b)
      0: return 8'(r & 255);
      1: return 8'((r >> 8) & 255);
      2: return {m_ovf[ch] != 0, m_valid, 1'b0, m_mode, 4'b0000};
      default: return 8'h00;
    endcase
  endfunction

  task automatic read_chk(input int ch, input int b);
    logic [7:0] e;
    @(negedge clk);
    rd_i = 1'b1;
    ch_sel_i = 3'(ch);
    byte_sel_i = 2'(b);
    exp_q.push_back(exp_byte(ch, b));
    @(negedge clk);
    rd_i = 1'b0;
    e = exp_q.pop_front();
    last_exp = e;
    check($sformatf("rd ch%0d b%0d", ch, b), 32'(data_o), 32'(e));
  endtask

  // one measurement; t = stop delay in clocks after start, 0 = never stops
  task automatic shot(input int t0, input int t1, input int t2, input int t3);
    int t [4];
    int maxk;
    bit to;
    t = '{t0, t1, t2, t3};
    maxk = 0;
    to = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (t[i] == 0) to = 1'b1;
      else if (t[i] > maxk) maxk = t[i];
    end
    if (to) maxk = 4095;
    @(negedge clk);
    start_i = 1'b1;
    model_begin();
    for (int k = 1; k <= maxk; k++) begin
      @(negedge clk);
      if (k == 1) check("busy armed", 32'(busy_o), 32'd1);
      for (int i = 0; i < 4; i++) if (t[i] == k) stop_i[2'(i)] = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      cap_v[i] = (t[i] == 0) ? 4095 : t[i];
      ov_v[i]  = (t[i] == 0) ? 1 : 0;
    end
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    stop_i  = 4'b0000;
    @(negedge clk);
    model_end();
    check("busy idle", 32'(busy_o), 32'd0);
    check("valid", 32'(valid_o), 32'(m_valid));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst data", 32'(data_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst valid", 32'(valid_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single-shot basic
    mode_i = 1'b0;
    shot(5, 9, 3, 3);
    for (int c = 0; c < 4; c++) read_chk(c, 0);
    read_chk(0, 2);

    // timeout with only ch0 stopping
    shot(100, 0, 0, 0);
    read_chk(0, 0);
    read_chk(1, 0);
    read_chk(1, 1);
    read_chk(3, 2);
    read_chk(0, 2);

    // coincident stop, start while armed, repeat stop
    @(negedge clk);
    start_i = 1'b1; stop_i[0] = 1'b1;
    model_begin();
    @(negedge clk); start_i = 1'b0; stop_i[0] = 1'b0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); stop_i[0] = 1'b1;
    @(negedge clk); stop_i[0] = 1'b0;
    @(negedge clk); stop_i[0] = 1'b1;
    @(negedge clk); stop_i[3:1] = 3'b111;
    repeat (3) @(negedge clk);
    stop_i = 4'b0000;
    @(negedge clk);
    cap_v = '{4, 7, 7, 7};
    ov_v  = '{0, 0, 0, 0};
    model_end();
    check("edge busy", 32'(busy_o), 32'd0);
    read_chk(0, 0);
    read_chk(1, 0);
    read_chk(1, 2);

    // readout byte selection and hold
    shot(1, 2748, 1, 1);
    read_chk(1, 0);
    read_chk(1, 1);
    read_chk(7, 0);
    read_chk(1, 3);
    read_chk(1, 0);
    ch_sel_i = 3'd2; byte_sel_i = 2'd1;
    repeat (3) @(negedge clk);
    check("hold", 32'(data_o), 32'(last_exp));

    // averaging batch
    mode_i = 1'b1;
    shot(10, 3, 3, 3);
    shot(11, 4, 4, 4);
    shot(12, 5, 5, 5);
    shot(14, 6, 6, 6);
    read_chk(0, 0);
    read_chk(1, 0);
    read_chk(0, 2);

    // reset in the middle of a batch
    shot(30, 2, 2, 2);
    shot(31, 2, 2, 2);
    shot(32, 2, 2, 2);
    @(negedge clk);
    start_i = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid rst data", 32'(data_o), 32'd0);
    check("mid rst busy", 32'(busy_o), 32'd0);
    check("mid rst valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    mode_i = 1'b1;
    shot(20, 6, 6, 6);
    shot(21, 6, 6, 6);
    shot(22, 6, 6, 6);
    shot(23, 6, 6, 6);
    read_chk(0, 0);
    read_chk(2, 0);
    read_chk(0, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
